// File: rtl/rand_delay_timer.sv
// rtl/rand_delay_timer.sv - randomized wait timer: go pulse MIN_TICKS + (rnd << SHIFT) ticks after arm
module rand_delay_timer #(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_TICKS = 1000,
  parameter int SHIFT     = 2,
  parameter int DLY_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rnd,
  input  logic             arm,
  input  logic             cancel,
  output logic             busy,
  output logic             go,
  output logic [DLY_W-1:0] delay_ticks
);

  // A prescaler of at least one bit keeps TICK_DIV=1 legal; it then wraps every cycle.
  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] load;

  // Fresh delay: the byte is widened to the counter width before shifting so no bits are lost.
  assign load = DLY_W'(MIN_TICKS) + (DLY_W'(rnd) << SHIFT);

  // Controller: accept arm in IDLE, count ticks in WAIT, pulse go in FIRE; cancel beats expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      go          <= 1'b0;
      delay_ticks <= '0;
      pre         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          go <= 1'b0;
          if (arm && !cancel) begin
            cnt         <= load;
            delay_ticks <= load;
            pre         <= '0;
            busy        <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pre == PRE_LAST) begin
            pre <= '0;
            if (cnt == DLY_W'(1)) begin
              cnt   <= '0;
              go    <= 1'b1;
              state <= FIRE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        FIRE: begin
          go    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          go    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_delay_timer.sv
// tb/tb_rand_delay_timer.sv - randomized self-checking bench for rand_delay_timer
module tb_rand_delay_timer;

  localparam int TD = 4;
  localparam int MT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm0, cancel0, busy0, go0;
  logic [7:0]  rnd0;
  logic [15:0] dly0;
  logic        arm2, cancel2, busy2, go2;
  logic [7:0]  rnd2;
  logic [15:0] dly2;

  int vectors = 0;
  int miscompares = 0;
  int exp_dly = 0;

  rand_delay_timer #(.TICK_DIV(TD), .MIN_TICKS(MT), .SHIFT(0), .DLY_W(16)) dut0 (
    .clk(clk), .rst(rst), .rnd(rnd0), .arm(arm0), .cancel(cancel0),
    .busy(busy0), .go(go0), .delay_ticks(dly0)
  );

  rand_delay_timer #(.TICK_DIV(TD), .MIN_TICKS(MT), .SHIFT(2), .DLY_W(16)) dut2 (
    .clk(clk), .rst(rst), .rnd(rnd2), .arm(arm2), .cancel(cancel2),
    .busy(busy2), .go(go2), .delay_ticks(dly2)
  );

  always #5 clk = ~clk;

  // Delay in ticks as stated by the rule MIN_TICKS + (rnd << SHIFT).
  function automatic int model_ticks(input int r, input int sh);
    return MT + r * (1 << sh);
  endfunction

  task automatic arm_pulse0(input logic [7:0] r);
    rnd0 = r;
    arm0 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
  endtask

  task automatic wait_go0(input int max, output int lat);
    lat = 0;
    while (go0 !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
    if (go0 !== 1'b1) lat = -1;
  endtask

  task automatic wait_go2(input int max, output int lat);
    lat = 0;
    while (go2 !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
    if (go2 !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b0; arm0 = 1'b1; cancel0 = 1'b0; rnd0 = 8'($urandom);
    arm2 = 1'b0; cancel2 = 1'b0; rnd2 = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy0, go0, dly0} !== 18'd0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: busy=%b go=%b delay=%0d, required 0/0/0", i, busy0, go0, dly0);
      end
    end
    rst = 1'b1; arm0 = 1'b0;
    @(negedge clk);
    arm_pulse0(8'd3);
    exp_dly = model_ticks(3, 0);
    vectors++;
    if (dly0 !== 16'(exp_dly)) begin
      miscompares++;
      $display("FAIL reset_first_delay: got %0d, required %0d", dly0, exp_dly);
    end
    vectors++;
    if (busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_busy: got %b, required 1", busy0);
    end
    wait_go0(200, lat);
    vectors++;
    if (lat !== 20) begin
      miscompares++;
      $display("FAIL reset_first_latency: got %0d, required 20", lat);
    end
    @(negedge clk);
    vectors++;
    if ({go0, busy0} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_go_width: go=%b busy=%b, required 0/0", go0, busy0);
    end
  endtask

  task automatic test_random_intervals();
    int lat, r;
    repeat (5) begin
      r = $urandom_range(0, 255);
      arm_pulse0(8'(r));
      exp_dly = model_ticks(r, 0);
      vectors++;
      if (dly0 !== 16'(exp_dly)) begin
        miscompares++;
        $display("FAIL rand_delay rnd=%0d: got %0d, required %0d", r, dly0, exp_dly);
      end
      wait_go0(2000, lat);
      vectors++;
      if (lat !== exp_dly * TD) begin
        miscompares++;
        $display("FAIL rand_latency rnd=%0d: got %0d, required %0d", r, lat, exp_dly * TD);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_range_bounds();
    int lat, r, e;
    for (int k = 0; k < 2; k++) begin
      r = (k == 0) ? 0 : 255;
      rnd2 = 8'(r);
      arm2 = 1'b1;
      @(negedge clk);
      arm2 = 1'b0;
      e = model_ticks(r, 2);
      vectors++;
      if (dly2 !== 16'(e)) begin
        miscompares++;
        $display("FAIL bound_delay rnd=%0d: got %0d, required %0d", r, dly2, e);
      end
      wait_go2(5000, lat);
      vectors++;
      if (lat !== e * TD) begin
        miscompares++;
        $display("FAIL bound_latency rnd=%0d: got %0d, required %0d", r, lat, e * TD);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cancel();
    int seen, r, k;
    for (int pass = 0; pass < 2; pass++) begin
      r = (pass == 0) ? 3 : $urandom_range(0, 15);
      arm_pulse0(8'(r));
      exp_dly = model_ticks(r, 0);
      k = (pass == 0) ? 10 : $urandom_range(1, exp_dly * TD - 1);
      repeat (k - 1) @(negedge clk);
      cancel0 = 1'b1;
      @(negedge clk);
      cancel0 = 1'b0;
      vectors++;
      if (busy0 !== 1'b0) begin
        miscompares++;
        $display("FAIL cancel_busy pass %0d: got %b, required 0", pass, busy0);
      end
      vectors++;
      if (dly0 !== 16'(exp_dly)) begin
        miscompares++;
        $display("FAIL cancel_delay_kept pass %0d: got %0d, required %0d", pass, dly0, exp_dly);
      end
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (go0 === 1'b1) seen = 1;
      end
      vectors++;
      if (seen !== 0) begin
        miscompares++;
        $display("FAIL cancel_no_go pass %0d: go seen=%0d, required 0", pass, seen);
      end
    end
  endtask

  task automatic test_simultaneous();
    int lat, r, seen;
    rnd0 = 8'($urandom); arm0 = 1'b1; cancel0 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0; cancel0 = 1'b0;
    vectors++;
    if ({busy0, dly0} !== {1'b0, 16'(exp_dly)}) begin
      miscompares++;
      $display("FAIL arm_cancel_idle: busy=%b delay=%0d, required 0/%0d", busy0, dly0, exp_dly);
    end
    r = $urandom_range(0, 15);
    arm_pulse0(8'(r));
    exp_dly = model_ticks(r, 0);
    repeat (exp_dly * TD - 1) @(negedge clk);
    cancel0 = 1'b1;
    @(negedge clk);
    cancel0 = 1'b0;
    seen = (go0 === 1'b1 || busy0 !== 1'b0) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (go0 === 1'b1) seen = 1;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL cancel_on_expiry: go/busy seen=%0d, required 0", seen);
    end
    r = $urandom_range(0, 31);
    arm_pulse0(8'(r));
    exp_dly = model_ticks(r, 0);
    lat = 0;
    while (go0 !== 1'b1 && lat < 2000) begin
      arm0 = 1'($urandom);
      rnd0 = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    arm0 = 1'b0;
    vectors++;
    if (lat !== exp_dly * TD) begin
      miscompares++;
      $display("FAIL wait_ignores_arm latency: got %0d, required %0d", lat, exp_dly * TD);
    end
    vectors++;
    if (dly0 !== 16'(exp_dly)) begin
      miscompares++;
      $display("FAIL wait_ignores_arm delay: got %0d, required %0d", dly0, exp_dly);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL after_fire_idle: busy=%b, required 0", busy0);
    end
  endtask

  task automatic test_reset_mid();
    int lat, r;
    r = $urandom_range(0, 255);
    arm_pulse0(8'(r));
    repeat ($urandom_range(1, 8)) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_dly = 0;
    vectors++;
    if ({busy0, go0, dly0} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_in_wait: busy=%b go=%b delay=%0d, required 0/0/0", busy0, go0, dly0);
    end
    r = $urandom_range(0, 7);
    arm_pulse0(8'(r));
    wait_go0(200, lat);
    vectors++;
    if (lat !== model_ticks(r, 0) * TD) begin
      miscompares++;
      $display("FAIL reset_fire_setup latency: got %0d, required %0d", lat, model_ticks(r, 0) * TD);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if ({busy0, go0, dly0} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_in_fire: busy=%b go=%b delay=%0d, required 0/0/0", busy0, go0, dly0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, r, e;
    arm0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 255);
      rnd0 = 8'(r);
      @(negedge clk);
      e = model_ticks(r, 0);
      vectors++;
      if (dly0 !== 16'(e) || dly0 < 16'd2 || dly0 > 16'd257 || busy0 !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_delay %0d: delay=%0d busy=%b, required %0d/1 in 2..257", k, dly0, busy0, e);
      end
      lat = 0;
      while (go0 !== 1'b1 && lat < 2000) begin
        rnd0 = 8'($urandom);
        @(negedge clk);
        lat++;
      end
      vectors++;
      if (lat !== e * TD) begin
        miscompares++;
        $display("FAIL b2b_latency %0d: got %0d, required %0d", k, lat, e * TD);
      end
      rnd0 = 8'($urandom);
      @(negedge clk);
      vectors++;
      if ({busy0, go0} !== 2'b00) begin
        miscompares++;
        $display("FAIL b2b_idle_gap %0d: busy=%b go=%b, required 0/0", k, busy0, go0);
      end
    end
    arm0 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release: busy=%b, required 0", busy0);
    end
  endtask

  initial begin
    test_reset();
    test_random_intervals();
    test_range_bounds();
    test_cancel();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/rand_delay_timer.md
# rand_delay_timer

Consumes the free-running 8-bit `out` byte of the `rng` block and turns it into a randomized wait interval for the project 2 reaction-timer path. On `arm` it samples the random byte and computes a delay of `MIN_TICKS + (rnd << SHIFT)` ticks, each tick being `TICK_DIV` clock cycles. It then counts the delay down and emits a one-cycle `go` pulse that cues the user and starts downstream timing. A `cancel` input aborts a pending wait without firing.

## Interface
- `TICK_DIV`, default 50000: clock cycles per tick (1 ms at 50 MHz); must be ≥ 1.
- `MIN_TICKS`, default 1000: fixed minimum delay in ticks; must be ≥ 1.
- `SHIFT`, default 2: left shift applied to the random byte.
- `DLY_W`, default 16: width of the tick counter and `delay_ticks`; requires `MIN_TICKS + (255 << SHIFT) < 2**DLY_W`.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `rnd`  in  8: random byte, wired to `rng` `out`; sampled only on an accepted `arm`.
- `arm`  in  1: start request; level-sampled each cycle.
- `cancel`  in  1: abort request; level-sampled each cycle.
- `busy`  out  1: high in WAIT and FIRE.
- `go`  out  1: one-cycle pulse when the delay expires.
- `delay_ticks`  out  DLY_W: delay loaded by the last accepted `arm`, held until the next accepted `arm` or reset.

## Operation
- States are IDLE, WAIT and FIRE. Outputs are registered or decoded from the state only; no combinational path from inputs to outputs.
- Reset (`rst`=0 at an edge):
  - state goes to IDLE;
  - `busy`=0, `go`=0, `delay_ticks`=0;
  - prescaler and tick counter go to 0.
  - Reset wins over every other input and in every state, including mid-WAIT and during FIRE.
- IDLE:
  - `arm`=1 and `cancel`=0: load `cnt = MIN_TICKS + ({DLY_W'b0,rnd} << SHIFT)`, zero-extended before shifting with no truncation. Copy `cnt` to `delay_ticks`, set `pre`=0 and go to WAIT.
  - `arm`=1 and `cancel`=1: no action; `cancel` has priority.
- WAIT:
  - `pre` increments every cycle.
  - When `pre == TICK_DIV-1`: `pre` returns to 0 and `cnt` decrements.
  - If `cnt==1` at that same edge, go to FIRE instead; `cnt` becomes 0.
  - `cancel`=1: go to IDLE at the next edge; `go` never asserts; `delay_ticks` keeps its value. Cancel beats expiry on the same edge.
  - `arm` is ignored, with no re-trigger or reload.
- FIRE:
  - `go`=1 for exactly this one cycle, then unconditionally back to IDLE.
  - `arm` and `cancel` are ignored.
- `rnd` is sampled only on the accepting edge. Later changes to `rnd` do not affect a pending wait.

## Timing
- `arm` accepted at edge N:
  - `busy`=1 from cycle N+1;
  - `go`=1 in the cycle following edge N + `delay_ticks`·`TICK_DIV`, for one cycle;
  - `busy` drops one cycle after `go`.
- Arm-to-go latency is exactly `delay_ticks`·`TICK_DIV` cycles, with no jitter. The earliest accepted re-arm is at the first edge where the state is IDLE, i.e. the edge after FIRE.
- Default range: 1000–2020 ticks, which is 1.000–2.020 s at 50 MHz.
- `TICK_DIV`=1 degenerates to one tick per cycle, with the same rules.
- `cancel` asserted at edge M in WAIT: `busy`=0 from cycle M+1.
- `arm` held high continuously:
  - re-accepted at the first IDLE edge after FIRE;
  - yields back-to-back intervals separated by exactly one FIRE cycle plus that IDLE accept cycle.

## Test plan
Test parameters unless stated: `TICK_DIV`=4, `MIN_TICKS`=2, `SHIFT`=0.

1. Reset: hold `rst`=0 for 3 edges with `arm`=1 → `busy`=0, `go`=0, `delay_ticks`=0 throughout; release and `arm` pulse with `rnd`=3 → `delay_ticks`=5 next cycle, `go` high for exactly 1 cycle exactly 20 cycles after the accepting edge.
2. Range bounds with `SHIFT`=2: `rnd`=0 → `delay_ticks`=2, `go` after 8 cycles; `rnd`=255 → `delay_ticks`=1022, `go` after 4088 cycles.
3. Cancel mid-wait: `rnd`=3, `cancel` pulse 10 cycles after arm → `busy`=0 next cycle, no `go` for 40 cycles, `delay_ticks` stays 5.
4. Simultaneous and ignored inputs:
   - `arm`+`cancel` same cycle in IDLE → stays IDLE, `delay_ticks` unchanged.
   - `cancel` on the expiry edge → no `go`.
   - `arm` and `rnd` changes during WAIT → no reload, `go` timing unchanged.
5. Reset mid-operation: `rst`=0 during WAIT and, separately, during FIRE → IDLE next cycle, `go`=0 immediately, all outputs at reset values.
6. Continuous `arm`=1 driven by a live `rng` instance → intervals equal `delay_ticks`·4, one FIRE cycle and one IDLE accept cycle between them; every `delay_ticks` lies in the range 2..257.
